// File: rtl/el2_ifu_align_seq.sv
// el2_ifu_align_seq: halfword aligner/sequencer between IFU fetch and decode.
// Buffers fetch words as 16-bit parcels and issues one 16/32-bit instruction per cycle.
module el2_ifu_align_seq #(
    parameter int BUF_HW = 4
) (
    input  logic        clk,
    input  logic        rst_l,
    input  logic        flush,
    input  logic [31:1] flush_pc,
    input  logic        fetch_valid,
    output logic        fetch_ready,
    input  logic [31:0] fetch_data,
    output logic [15:0] cmp_din,
    input  logic [31:0] cmp_dout,
    output logic        dec_valid,
    input  logic        dec_ready,
    output logic [31:0] dec_inst,
    output logic [31:1] dec_pc,
    output logic        dec_is16,
    output logic [15:0] dec_cinst,
    output logic        dec_illegal
);
    localparam int CW = $clog2(BUF_HW + 1);

    logic [15:0]   h  [BUF_HW];
    logic [15:0]   nh [BUF_HW];
    logic [CW-1:0] cnt;
    logic [31:1]   head_pc;
    logic          skip_lo;
    logic          is32, push, pop;
    logic [1:0]    npush, npop;
    int            rem;

    assign is32        = h[0][1:0] == 2'b11;
    assign fetch_ready = !flush && (int'(cnt) <= BUF_HW - 2);
    assign dec_valid   = !flush && (is32 ? cnt >= CW'(2) : cnt != '0);
    assign push        = fetch_valid && fetch_ready;
    assign pop         = dec_valid && dec_ready;
    assign npush       = push ? (skip_lo ? 2'd1 : 2'd2) : 2'd0;
    assign npop        = pop ? (is32 ? 2'd2 : 2'd1) : 2'd0;
    assign rem         = int'(cnt) - int'(npop);

    assign cmp_din     = h[0];
    assign dec_inst    = is32 ? {h[1], h[0]} : cmp_dout;
    assign dec_pc      = head_pc;
    // Gated by cnt so the empty buffer reports a clean non-16-bit idle state
    assign dec_is16    = !is32 && cnt != '0;
    assign dec_cinst   = dec_is16 ? h[0] : 16'h0;
    assign dec_illegal = dec_is16 && cmp_dout == 32'h0;

    // Survivors shift down by the pop count, new parcels land right after them
    always_comb begin
        for (int i = 0; i < BUF_HW; i++) begin
            nh[i] = (i + int'(npop) < BUF_HW) ? h[i + int'(npop)] : h[i];
            if (i == rem && npush != 2'd0)
                nh[i] = skip_lo ? fetch_data[31:16] : fetch_data[15:0];
            if (i == rem + 1 && npush == 2'd2)
                nh[i] = fetch_data[31:16];
        end
    end

    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            h       <= '{default: '0};
            cnt     <= '0;
            head_pc <= '0;
            skip_lo <= 1'b0;
        end else if (flush) begin
            cnt     <= '0;
            head_pc <= flush_pc;
            skip_lo <= flush_pc[1];
        end else begin
            h       <= nh;
            cnt     <= cnt + CW'(npush) - CW'(npop);
            head_pc <= head_pc + 31'(npop);
            if (push)
                skip_lo <= 1'b0;
        end
    end
endmodule

// File: doc/el2_ifu_align_seq.md
# el2_ifu_align_seq

Halfword instruction aligner and sequencer between the IFU fetch path and decode. It buffers 32-bit fetch words as 16-bit parcels and carves out one 16-bit or 32-bit instruction per cycle. Compressed parcels are routed through the external compressed-instruction decompressor, and the 32-bit result is presented to decode with its PC under a valid/ready handshake.

## Interface
- BUF_HW, 4, halfword buffer capacity; legal range 3..8.
- clk  in  1  core clock; all state updates on the rising edge.
- rst_l  in  1  asynchronous active-low reset.
- flush  in  1  redirect; discards all buffered parcels.
- flush_pc  in  31  [31:1] redirect target halfword address.
- fetch_valid  in  1  fetch word offered.
- fetch_ready  out  1  aligner accepts the word this cycle.
- fetch_data  in  32  fetch word; [15:0] is the lower-address halfword.
- cmp_din  out  16  head parcel driven to the decompressor.
- cmp_dout  in  32  decompressor result; 0 means illegal.
- dec_valid  out  1  instruction presented to decode.
- dec_ready  in  1  decode consumes the instruction.
- dec_inst  out  32  expanded or native 32-bit instruction.
- dec_pc  out  31  [31:1] instruction address.
- dec_is16  out  1  instruction came from a 16-bit parcel.
- dec_cinst  out  16  raw parcel when dec_is16=1, else 0.
- dec_illegal  out  1  compressed parcel decoded as illegal.

## Operation
- **Buffer:** halfword FIFO with entries h0..h(BUF_HW-1), counter cnt (0..BUF_HW), and register head_pc.
- **Fetch accept:** fetch_ready = !flush & (BUF_HW - cnt >= 2). The ready computation ignores a same-cycle pop.
- **Push on accept:**
  - If skip_lo=1: push only fetch_data[31:16], then clear skip_lo.
  - Otherwise: push fetch_data[15:0] first, then [31:16].
- **Instruction formation (h0[1:0]):**
  - h0[1:0]!=2'b11: 16-bit instruction.
    - Needs cnt>=1.
    - dec_inst=cmp_dout, dec_is16=1, dec_cinst=h0.
    - dec_illegal = (cmp_dout==0).
  - h0[1:0]==2'b11: 32-bit instruction.
    - Needs cnt>=2.
    - dec_inst={h1,h0}, dec_is16=0, dec_cinst=0, dec_illegal=0.
- **Decompressor drive:** cmp_din=h0 at all times, including when cnt=0, so the downstream path is purely combinational.
- **dec_valid:** 1 when the head instruction is complete and flush=0.
  - 32-bit head with cnt=1 gives dec_valid=0, waiting for the upper half.
- **Pop:** on dec_valid & dec_ready, pop 1 (16-bit) or 2 (32-bit) parcels and advance head_pc by the same count. The address wraps modulo 2^31.
- **Simultaneous push and pop:** allowed. Next cnt = cnt + pushed - popped, and surviving entries shift toward h0 before the new parcels are appended.
- **Flush has priority over every other event:**
  - Next cnt=0, head_pc=flush_pc, skip_lo=flush_pc[1].
  - A fetch offered in the flush cycle is not accepted (fetch_ready=0).
  - No decode handshake occurs in the flush cycle (dec_valid=0).
- **Illegal compressed instructions:** still presented and popped normally. Decode owns the exception.
- **Debug outputs:** dec_inst, dec_pc, dec_is16 and dec_cinst are meaningful only when dec_valid=1, but stay deterministic for debug.

## Timing
- **Reset (asynchronous, rst_l=0):**
  - State: cnt=0, head_pc=0, skip_lo=0, all hN=0.
  - Outputs: dec_valid=0, fetch_ready=1, cmp_din=0, dec_pc=0, dec_cinst=0, dec_is16=0, dec_illegal=0.
  - dec_inst equals whatever the decompressor returns for input 0.
- **Latency:**
  - A fetch word accepted in cycle N is visible in cycle N+1.
  - An instruction fully contained in that word raises dec_valid in N+1.
  - No combinational path from fetch_valid or fetch_data to dec_* outputs.
- **Throughput:** at most one instruction per cycle. Two 16-bit instructions in one word take two cycles.
- **Full buffer:** with cnt>BUF_HW-2, fetch_ready=0. It recovers the cycle after a pop lowers cnt.
- **Reset mid-operation:** all state returns to the reset values immediately; no partial instruction survives.

## Test plan
- **Reset, then compressed word:** release reset, flush with flush_pc=0x40, accept fetch_data=0x00014501.
  - Next cycle: dec_valid=1, dec_pc=0x40 (byte 0x80), dec_is16=1, dec_inst=0x00000513.
  - Following cycle: dec_pc=0x41, dec_inst=0x00000013.
- **Straddling 32-bit instruction:** flush with flush_pc[1]=1, then accept 0x0513xxxx and 0x00000000.
  - Cycle after the first fetch: dec_valid=0 (cnt=1).
  - Cycle after the second fetch: dec_inst=0x00000513, dec_is16=0.
- **Backpressure:** hold dec_ready=0 and offer continuous fetches.
  - fetch_ready drops once cnt>=BUF_HW-1 (cnt=3 with BUF_HW=4).
  - No parcel is lost or duplicated after dec_ready returns to 1.
- **Illegal parcel:** fetch_data=0x00000000.
  - dec_illegal=1, dec_is16=1, dec_inst=0.
  - The parcel is popped and dec_pc advances by 1.
- **Flush in a push+pop cycle:** assert flush while fetch_valid=1 and dec_ready=1.
  - fetch_ready=0 and dec_valid=0 in that cycle.
  - Next cycle: cnt=0 and head_pc=flush_pc.
- **Asynchronous reset:** assert rst_l=0 between clock edges with cnt=3.
  - dec_valid drops immediately and fetch_ready=1 before the next edge.
